sfp_accum_buf: RTL and testbench

Parametrised successor to the per-column SFP: a COL-lane signed partial-sum accumulator with a DEPTH-entry internal buffer, saturating arithmetic, optional ReLU and a valid/ready drain port. It sits between the corelet output FIFO and pmem. Partial sums for several output addresses accumulate on chip across kernel passes. Finished results are then streamed out, and each drained entry is cleared.

---
 rtl/sfp_pkg.sv | 31 +++
 rtl/sfp_lane.sv | 33 +++
 rtl/sfp_accum_buf.sv | 160 ++++++++++++++++
 tb/tb_sfp_accum_buf.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_pkg.sv
// Shared types and saturation helpers for the SFP family of post-processing blocks.
package sfp_pkg;

  typedef enum logic {
    ACC   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Clamp a wide signed value into a signed range of the given width.
  function automatic logic signed [63:0] clamp_signed(input logic signed [63:0] value,
                                                      input int                 width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  function automatic logic signed [63:0] sat_acc(input logic signed [63:0] value,
                                                 input int                 width);
    return clamp_signed(value, width);
  endfunction

  function automatic logic signed [63:0] clamp_out(input logic signed [63:0] value,
                                                   input int                 width);
    return clamp_signed(value, width);
  endfunction

endpackage

// File: rtl/sfp_lane.sv
// One lane of the SFP datapath: saturating accumulate plus optional ReLU and output clamp.
module sfp_lane
  import sfp_pkg::*;
#(
  parameter int IN_BW  = 16,
  parameter int ACC_BW = 20,
  parameter int OUT_BW = 16
) (
  input  logic signed [ACC_BW-1:0] acc_cur,
  input  logic signed [IN_BW-1:0]  psum,
  output logic signed [ACC_BW-1:0] acc_next,
  output logic                     sat,
  input  logic signed [ACC_BW-1:0] drain_src,
  input  logic                     relu,
  output logic signed [OUT_BW-1:0] drain_out
);

  logic signed [63:0] sum_wide;
  logic signed [63:0] sum_sat;
  logic signed [63:0] relu_val;
  logic signed [63:0] out_wide;

  always_comb begin
    sum_wide  = 64'(acc_cur) + 64'(psum);
    sum_sat   = sat_acc(sum_wide, ACC_BW);
    acc_next  = ACC_BW'(sum_sat);
    sat       = (sum_sat != sum_wide);
    relu_val  = (relu && (drain_src < 0)) ? 64'sd0 : 64'(drain_src);
    out_wide  = clamp_out(relu_val, OUT_BW);
    drain_out = OUT_BW'(out_wide);
  end

endmodule

// File: rtl/sfp_accum_buf.sv
// COL-lane partial-sum accumulator with a DEPTH-entry flop buffer and a clear-on-drain output port.
module sfp_accum_buf
  import sfp_pkg::*;
#(
  parameter int COL    = 8,
  parameter int IN_BW  = 16,
  parameter int ACC_BW = 20,
  parameter int OUT_BW = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [COL*IN_BW-1:0]    in_data,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic                    drain_start,
  input  logic                    relu_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COL*OUT_BW-1:0]   out_data,
  output logic [ADDR_W-1:0]       out_addr,
  output logic                    drain_done,
  output logic                    sat_flag
);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       ptr_q, ptr_d, ptr_nxt, drain_idx;
  logic                    relu_q, relu_d, relu_sel;
  logic                    sat_q, sat_d;
  logic                    out_valid_q, out_valid_d;
  logic [COL*OUT_BW-1:0]   out_data_q, out_data_d, drain_pack;
  logic [ADDR_W-1:0]       out_addr_q, out_addr_d;
  logic                    drain_done_q, drain_done_d;

  logic signed [ACC_BW-1:0] entry_q [DEPTH][COL];
  logic signed [ACC_BW-1:0] entry_d [DEPTH][COL];

  logic signed [ACC_BW-1:0] acc_cur   [COL];
  logic signed [ACC_BW-1:0] acc_next  [COL];
  logic signed [ACC_BW-1:0] drain_src [COL];
  logic signed [OUT_BW-1:0] drain_out [COL];
  logic [COL-1:0]           sat_lane;

  logic accept;
  logic handshake;
  logic first_hit;

  assign in_ready  = !reset && (state_q == ACC);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_q && out_ready;
  assign ptr_nxt   = ptr_q + ADDR_W'(1);
  assign drain_idx = (state_q == ACC) ? '0 : ptr_nxt;
  assign relu_sel  = (state_q == ACC) ? relu_en : relu_q;
  // A same-cycle accept to entry 0 must be visible in the first drained vector.
  assign first_hit = accept && (in_addr == '0);

  for (genvar k = 0; k < COL; k++) begin : g_lane
    assign acc_cur[k]   = entry_q[in_addr][k];
    assign drain_src[k] = first_hit ? acc_next[k] : entry_q[drain_idx][k];

    sfp_lane #(
      .IN_BW  (IN_BW),
      .ACC_BW (ACC_BW),
      .OUT_BW (OUT_BW)
    ) u_lane (
      .acc_cur   (acc_cur[k]),
      .psum      (in_data[k*IN_BW +: IN_BW]),
      .acc_next  (acc_next[k]),
      .sat       (sat_lane[k]),
      .drain_src (drain_src[k]),
      .relu      (relu_sel),
      .drain_out (drain_out[k])
    );

    assign drain_pack[k*OUT_BW +: OUT_BW] = drain_out[k];
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    relu_d       = relu_q;
    sat_d        = sat_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_addr_d   = out_addr_q;
    drain_done_d = 1'b0;
    entry_d      = entry_q;

    if (accept) begin
      for (int k = 0; k < COL; k++) entry_d[in_addr][k] = acc_next[k];
      sat_d = sat_q || (|sat_lane);
    end

    case (state_q)
      ACC: begin
        if (drain_start) begin
          state_d     = DRAIN;
          relu_d      = relu_en;
          ptr_d       = '0;
          sat_d       = accept && (|sat_lane);
          out_valid_d = 1'b1;
          out_data_d  = drain_pack;
          out_addr_d  = '0;
        end
      end
      DRAIN: begin
        if (handshake) begin
          for (int k = 0; k < COL; k++) entry_d[ptr_q][k] = '0;
          if (ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_d      = ACC;
            ptr_d        = '0;
            out_valid_d  = 1'b0;
            out_data_d   = '0;
            out_addr_d   = '0;
            drain_done_d = 1'b1;
          end else begin
            ptr_d      = ptr_nxt;
            out_addr_d = ptr_nxt;
            out_data_d = drain_pack;
          end
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ACC;
      ptr_q        <= '0;
      relu_q       <= 1'b0;
      sat_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_addr_q   <= '0;
      drain_done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        for (int k = 0; k < COL; k++) entry_q[i][k] <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      relu_q       <= relu_d;
      sat_q        <= sat_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_addr_q   <= out_addr_d;
      drain_done_q <= drain_done_d;
      entry_q      <= entry_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign drain_done = drain_done_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_sfp_accum_buf.sv
// Directed bench for sfp_accum_buf: accumulate, saturate, ReLU, stalled drain and reset abort.
module tb_sfp_accum_buf;

  localparam int COL    = 8;
  localparam int IN_BW  = 16;
  localparam int OUT_BW = 16;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [COL*IN_BW-1:0]  in_data;
  logic [AW-1:0]         in_addr;
  logic                  drain_start;
  logic                  relu_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [COL*OUT_BW-1:0] out_data;
  logic [AW-1:0]         out_addr;
  logic                  drain_done;
  logic                  sat_flag;

  sfp_accum_buf #(
    .COL    (COL),
    .IN_BW  (IN_BW),
    .ACC_BW (20),
    .OUT_BW (OUT_BW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_addr     (in_addr),
    .drain_start (drain_start),
    .relu_en     (relu_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .drain_done  (drain_done),
    .sat_flag    (sat_flag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [COL*OUT_BW-1:0] got_data [DEPTH];
  logic [COL*OUT_BW-1:0] exp_data [DEPTH];
  int got_cnt, done_cnt, done_cyc;
  bit order_ok, stable_ok, ready_low_ok;

  function automatic logic [127:0] vec3(input int l0, input int l1, input int l2);
    logic [127:0] v;
    v = '0;
    v[15:0]  = l0[15:0];
    v[31:16] = l1[15:0];
    v[47:32] = l2[15:0];
    return v;
  endfunction

  task automatic accept(input int addr, input logic [127:0] v);
    in_valid = 1'b1;
    in_addr  = addr[3:0];
    in_data  = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < DEPTH; i++) exp_data[i] = '0;
  endtask

  // Issues drain_start and collects every handshaken vector until drain_done (bounded).
  task automatic run_drain(input logic relu, input bit stall);
    int cyc;
    logic [127:0] sd;
    logic [3:0] sa;
    bit stalled;
    drain_start = 1'b1;
    relu_en     = relu;
    out_ready   = 1'b0;
    @(posedge clk); #1;
    drain_start = 1'b0;
    relu_en     = 1'b0;
    for (int i = 0; i < DEPTH; i++) got_data[i] = 'x;
    got_cnt = 0; done_cnt = 0; done_cyc = -1;
    order_ok = 1; stable_ok = 1; ready_low_ok = 1;
    cyc = 0;
    while (done_cnt == 0 && cyc < 300) begin
      out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      if (in_ready !== 1'b0) ready_low_ok = 0;
      stalled = (out_valid === 1'b1) && !out_ready;
      sd = out_data;
      sa = out_addr;
      if (out_valid === 1'b1 && out_ready) begin
        if (got_cnt < DEPTH) got_data[got_cnt] = out_data;
        if (out_addr !== got_cnt[3:0]) order_ok = 0;
        got_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
      if (stalled && (out_valid !== 1'b1 || out_data !== sd || out_addr !== sa)) stable_ok = 0;
      if (drain_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    total++; if (out_addr !== '0) begin bad++; $display("FAIL rst_out_addr got=%h exp=0", out_addr); end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready c=%0d got=%b exp=1", c, in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_valid c=%0d got=%b exp=0", c, out_valid); end
      total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL idle_sat c=%0d got=%b exp=0", c, sat_flag); end
      total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL idle_done c=%0d got=%b exp=0", c, drain_done); end
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_accum_drain();
    accept(2, vec3(5, 0, 0));
    accept(2, vec3(-3, 0, 0));
    accept(2, vec3(100, 0, 0));
    run_drain(1'b0, 1'b0);
    clear_exp();
    exp_data[2] = vec3(102, 0, 0);
    total++; if (got_cnt !== DEPTH) begin bad++; $display("FAIL acc_count got=%0d exp=%0d", got_cnt, DEPTH); end
    total++; if (done_cyc !== DEPTH) begin bad++; $display("FAIL acc_done_cycle got=%0d exp=%0d", done_cyc, DEPTH); end
    total++; if (!order_ok) begin bad++; $display("FAIL acc_order got=0 exp=1"); end
    total++; if (!ready_low_ok) begin bad++; $display("FAIL acc_in_ready_drain got=1 exp=0"); end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (got_data[i] !== exp_data[i]) begin
        bad++; $display("FAIL acc_entry addr=%0d got=%h exp=%h", i, got_data[i], exp_data[i]);
      end
    end
    @(posedge clk); #1;
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL acc_done_pulse got=%b exp=0", drain_done); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL acc_back_to_acc got=%b exp=1", in_ready); end
  endtask

  task automatic test_relu_clear();
    accept(0, vec3(-7, 9, 0));
    run_drain(1'b1, 1'b0);
    total++; if (got_data[0] !== vec3(0, 9, 0)) begin bad++; $display("FAIL relu_entry0 got=%h exp=%h", got_data[0], vec3(0, 9, 0)); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL relu_done got=%0d exp=1", done_cnt); end
    run_drain(1'b0, 1'b0);
    clear_exp();
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (got_data[i] !== exp_data[i]) begin
        bad++; $display("FAIL clear_entry addr=%0d got=%h exp=%h", i, got_data[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int cyc;
    // Entered on the drain_done cycle of the previous drain: first accept is legal here.
    accept(1, vec3(32767, -32768, 0));
    total++; if (drain_done !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL sat_post_done got=%b%b exp=00", drain_done, out_valid); end
    repeat (15) accept(1, vec3(32767, -32768, 0));
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL sat_boundary got=%b exp=0", sat_flag); end
    accept(1, vec3(32767, -32768, 0));
    total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_set got=%b exp=1", sat_flag); end
    repeat (16) accept(1, vec3(-32767, 32767, 0));
    total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_sticky got=%b exp=1", sat_flag); end
    run_drain(1'b0, 1'b0);
    total++; if (got_data[1] !== vec3(15, -16, 0)) begin bad++; $display("FAIL sat_entry1 got=%h exp=%h", got_data[1], vec3(15, -16, 0)); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL sat_clear got=%b exp=0", sat_flag); end
    repeat (16) accept(1, vec3(32767, 0, 0));
    run_drain(1'b0, 1'b0);
    total++; if (got_data[1] !== vec3(32767, 0, 0)) begin bad++; $display("FAIL out_clamp got=%h exp=%h", got_data[1], vec3(32767, 0, 0)); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL sat_drain_silent got=%b exp=0", sat_flag); end
    // Saturating accept coinciding with drain_start: the set must win over the clear.
    repeat (16) accept(3, vec3(32767, 0, 0));
    in_valid = 1'b1; in_addr = 4'd3; in_data = vec3(32767, 0, 0); drain_start = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0; drain_start = 1'b0;
    total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_set_wins got=%b exp=1", sat_flag); end
    out_ready = 1'b1;
    cyc = 0;
    while (drain_done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    total++; if (drain_done !== 1'b1) begin bad++; $display("FAIL sat_set_wins_done got=%b exp=1", drain_done); end
  endtask

  task automatic test_stall();
    accept(3, vec3(11, 0, 0));
    accept(15, vec3(0, 0, -4));
    run_drain(1'b0, 1'b1);
    clear_exp();
    exp_data[3]  = vec3(11, 0, 0);
    exp_data[15] = vec3(0, 0, -4);
    total++; if (got_cnt !== DEPTH) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", got_cnt, DEPTH); end
    total++; if (!order_ok) begin bad++; $display("FAIL stall_order got=0 exp=1"); end
    total++; if (!stable_ok) begin bad++; $display("FAIL stall_stable got=0 exp=1"); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL stall_done got=%0d exp=1", done_cnt); end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (got_data[i] !== exp_data[i]) begin
        bad++; $display("FAIL stall_entry addr=%0d got=%h exp=%h", i, got_data[i], exp_data[i]);
      end
    end
    repeat (3) begin
      @(posedge clk); #1;
      total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL stall_done_once got=%b exp=0", drain_done); end
    end
  endtask

  task automatic test_same_cycle_reset();
    accept(7, vec3(77, 0, 0));
    in_valid = 1'b1; in_addr = 4'd0; in_data = vec3(42, 0, 0);
    drain_start = 1'b1; relu_en = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL same_valid got=%b exp=1", out_valid); end
    total++; if (out_addr !== 4'd0) begin bad++; $display("FAIL same_addr got=%0d exp=0", out_addr); end
    total++; if (out_data !== vec3(42, 0, 0)) begin bad++; $display("FAIL same_data got=%h exp=%h", out_data, vec3(42, 0, 0)); end
    // drain_start stays high through the drain and must be ignored.
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b0;
    drain_start = 1'b0;
    total++; if (out_addr !== 4'd5 || out_valid !== 1'b1) begin bad++; $display("FAIL same_ptr5 got=%0d/%b exp=5/1", out_addr, out_valid); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b exp=0", out_valid); end
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", drain_done); end
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if (drain_done !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL abort_after got=%b/%b exp=0/1", drain_done, in_ready); end
    run_drain(1'b0, 1'b0);
    clear_exp();
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL abort_redrain_done got=%0d exp=1", done_cnt); end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (got_data[i] !== exp_data[i]) begin
        bad++; $display("FAIL abort_entry addr=%0d got=%h exp=%h", i, got_data[i], exp_data[i]);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_addr     = '0;
    drain_start = 1'b0;
    relu_en     = 1'b0;
    out_ready   = 1'b0;
    test_reset();
    test_accum_drain();
    test_relu_clear();
    test_saturation();
    test_stall();
    test_same_cycle_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
